cgra_apb_csr_mc: RTL
====================

Name: cgra_apb_csr_mc

Overview:
Parametrised multi-channel successor to the single-DMA CGRA CSR block. It is an APB slave holding configuration for NUM_CH DMA channels plus the control unit (CU). Starts are delivered to the DMA engines and the CU via valid/ready handshakes, with illegal accesses rejected. IRQ status is sticky and write-1-to-clear, and each channel keeps a completion counter.

Parameters:
NUM_CH, 4, number of DMA channels (1..8)
ADDR_WIDTH, 32, APB paddr width
DATA_WIDTH, 32, APB data width; all registers are DATA_WIDTH wide
CNT_WIDTH, 16, per-channel done-counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
psel/penable/pwrite  in  1 each  APB control
paddr  in  ADDR_WIDTH  APB address (bits [8:0] decoded)
pwdata  in  DATA_WIDTH  write data
prdata  out  DATA_WIDTH  read data
pready  out  1  constant 1
pslverr  out  1  error response
dma_src  out  NUM_CH*32  per-channel source address, channel n at [32n+:32]
dma_dst  out  NUM_CH*32  per-channel destination address
dma_size  out  NUM_CH*32  per-channel byte count
dma_start_valid  out  NUM_CH  start request, held until accepted
dma_start_ready  in  NUM_CH  engine accepts start
dma_busy_i  in  NUM_CH  engine busy
dma_done_i  in  NUM_CH  one-cycle completion pulse
cu_start_valid  out  1  CU start request
cu_start_ready  in  1  CU accepts start
cu_soft_reset  out  1  level, CU_CTRL[1]
cu_busy_i  in  1  CU busy
cu_done_i  in  1  CU completion pulse
cu_cycles_i  in  32  CU cycle counter
irq  out  1  interrupt

Behaviour:
- Reset (async, rst=1): all registers, valids, sticky bits, counters and irq go to 0.
- Address map:
  - 0x000 ID: RO, 0x43470000 | NUM_CH.
  - 0x004 IRQ_STATUS: W1C; bit n = channel n done, bit 8 = CU done.
  - 0x008 IRQ_MASK: RW.
  - 0x010 CU_CTRL: [0] start W1S, [1] soft_reset RW.
  - 0x014 CU_STATUS: RO, [0] busy, [1] done, [2] pending.
  - 0x018 CU_CYCLES: RO.
  - Channel n at 0x100 + 0x20·n: +0 CTRL ([0] start W1S); +4 STATUS (RO: [0] busy, [1] done, [2] pending, [3] err, W1C on bit 3 only); +8 SRC; +C DST; +10 SIZE; +14 DONE_CNT (RO; a write of any value clears it); +18 PERF (see Optional Feature).
- APB: zero wait states; a write commits on psel&penable&pwrite; prdata is combinational from paddr. Unmapped address, or a channel index ≥ NUM_CH: read returns 0xDEADBEEF with pslverr=1; write is ignored with pslverr=1.
- Start, per channel:
  - Writing CTRL[0]=1 when the channel is not pending, not busy and SIZE≠0 sets pending. dma_start_valid[n]=pending.
  - Pending clears the cycle after valid&ready are both high.
  - Start while pending or busy, or with SIZE=0: write ignored, pslverr=1, STATUS.err set.
- CU start follows the same rules, except the SIZE check does not apply.
- While a channel is pending, writes to its SRC/DST/SIZE are rejected with pslverr=1. Outputs stay stable from the request through acceptance.
- Done handling: dma_done_i[n] sets STATUS.done and IRQ_STATUS[n], and increments DONE_CNT, saturating at 2^CNT_WIDTH−1. STATUS.done clears on acceptance of the next start.
  - Done together with a same-cycle W1C of the same IRQ bit: set wins.
  - Done together with a DONE_CNT clear: the counter becomes 1.
- irq: registered, irq <= |(IRQ_STATUS & IRQ_MASK[8:0]); 1-cycle latency from a status or mask change.
- cu_soft_reset is a plain level output; the block does not self-clear it.

Optional Feature:
Macro CGRA_CSR_PERF_EN.
- Defined: each channel has a 32-bit PERF counter that increments every cycle dma_busy_i[n]=1 and wraps at 2^32. It clears on acceptance of a start, and a write to PERF also clears it.
- Undefined: the PERF offset reads 0 with pslverr=0, writes to it are ignored, and no counter logic is present.

Test Plan:
- Reset, then read 0x000 with NUM_CH=4 → 0x43470004, and pslverr=0.
- Ch1: write SRC=0x1000, DST=0x2000, SIZE=0x40, then CTRL=1 → dma_start_valid[1]=1 with those outputs. Hold ready low 3 cycles → valid stays high. Ready=1 → valid drops the next cycle.
- Ch1 pending: write SIZE → pslverr=1, SIZE unchanged. Write CTRL=1 → pslverr=1 and STATUS=0x4|0x8. Write STATUS=0x8 → err cleared.
- Ch0 SIZE=0, CTRL=1 → pslverr=1 and no valid.
- MASK=0x101 and pulse dma_done_i[0] → irq=1 one cycle later. Pulse cu_done_i while writing IRQ_STATUS=0x100 in the same cycle → bit 8 stays set. Write 0x101 → irq=0 one cycle later.
- Pulse dma_done_i[2] 3 times → DONE_CNT=3. Read 0x1A0 (ch5, NUM_CH=4) → 0xDEADBEEF with pslverr=1. With PERF_EN: busy held 10 cycles → PERF=10.

Source files
------------

// File: rtl/cgra_apb_csr_mc.sv
// APB CSR block for NUM_CH DMA channels plus the CGRA control unit.
// Optional per-channel busy-cycle counters under `CGRA_CSR_PERF_EN.
module cgra_apb_csr_mc #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [NUM_CH*32-1:0]    dma_src,
    output logic [NUM_CH*32-1:0]    dma_dst,
    output logic [NUM_CH*32-1:0]    dma_size,
    output logic [NUM_CH-1:0]       dma_start_valid,
    input  logic [NUM_CH-1:0]       dma_start_ready,
    input  logic [NUM_CH-1:0]       dma_busy_i,
    input  logic [NUM_CH-1:0]       dma_done_i,
    output logic                    cu_start_valid,
    input  logic                    cu_start_ready,
    output logic                    cu_soft_reset,
    input  logic                    cu_busy_i,
    input  logic                    cu_done_i,
    input  logic [31:0]             cu_cycles_i,
    output logic                    irq
);

    localparam logic [31:0] ID_VAL = 32'h4347_0000 | 32'(NUM_CH);

    logic [31:0]          src_q  [NUM_CH];
    logic [31:0]          src_d  [NUM_CH];
    logic [31:0]          dst_q  [NUM_CH];
    logic [31:0]          dst_d  [NUM_CH];
    logic [31:0]          size_q [NUM_CH];
    logic [31:0]          size_d [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [NUM_CH-1:0]    err_q, err_d;
    logic [8:0]           ist_q, ist_d;
    logic [31:0]          mask_q, mask_d;
    logic                 cu_pend_q, cu_pend_d;
    logic                 cu_done_q, cu_done_d;
    logic                 cu_srst_q, cu_srst_d;
    logic                 irq_q;

    logic [8:0]        a;
    logic [2:0]        ch;
    logic [4:0]        off;
    logic              acc, wr, ch_ok, g_hit, wr_err;
    logic [31:0]       wd, rd;
    logic [NUM_CH-1:0] ch_sel, ch_acc;
    logic              cu_acc;
    logic              unused_addr;

    assign a     = paddr[8:0];
    assign ch    = a[7:5];
    assign off   = a[4:0];
    assign acc   = psel & penable;
    assign wr    = acc & pwrite;
    assign wd    = 32'(pwdata);
    assign unused_addr = ^paddr[ADDR_WIDTH-1:9];

    assign ch_ok = a[8] && (int'(ch) < NUM_CH) &&
                   (off inside {5'h00, 5'h04, 5'h08, 5'h0C,
                                5'h10, 5'h14, 5'h18});
    assign g_hit = !a[8] &&
                   (a inside {9'h000, 9'h004, 9'h008,
                              9'h010, 9'h014, 9'h018});

    assign ch_acc = pend_q & dma_start_ready;
    assign cu_acc = cu_pend_q & cu_start_ready;

    always_comb begin
        ch_sel = '0;
        for (int n = 0; n < NUM_CH; n++)
            ch_sel[n] = wr && ch_ok && (ch == 3'(n));
    end

    // Rejected writes flag wr_err; a done pulse always wins over a clear.
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q & ~ch_acc;
        done_d    = done_q & ~ch_acc;
        err_d     = err_q;
        ist_d     = ist_q;
        mask_d    = mask_q;
        cu_pend_d = cu_pend_q & ~cu_acc;
        cu_done_d = cu_done_q & ~cu_acc;
        cu_srst_d = cu_srst_q;
        wr_err    = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_sel[n]) begin
                case (off)
                    5'h00: if (wd[0]) begin
                        if (pend_q[n] || dma_busy_i[n] || size_q[n] == '0) begin
                            wr_err   = 1'b1;
                            err_d[n] = 1'b1;
                        end else begin
                            pend_d[n] = 1'b1;
                        end
                    end
                    5'h04: if (wd[3]) err_d[n] = 1'b0;
                    5'h08: if (pend_q[n]) wr_err = 1'b1; else src_d[n] = wd;
                    5'h0C: if (pend_q[n]) wr_err = 1'b1; else dst_d[n] = wd;
                    5'h10: if (pend_q[n]) wr_err = 1'b1; else size_d[n] = wd;
                    5'h14: cnt_d[n] = '0;
                    default: ;
                endcase
            end
            if (dma_done_i[n]) begin
                done_d[n] = 1'b1;
                if (cnt_d[n] != '1)
                    cnt_d[n] = cnt_d[n] + CNT_WIDTH'(1);
            end
        end
        if (wr && g_hit) begin
            case (a)
                9'h004: ist_d  = ist_q & ~wd[8:0];
                9'h008: mask_d = wd;
                9'h010: begin
                    if (wd[0] && (cu_pend_q || cu_busy_i)) begin
                        wr_err = 1'b1;
                    end else begin
                        cu_srst_d = wd[1];
                        if (wd[0]) cu_pend_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        ist_d = ist_d | 9'(dma_done_i);
        if (cu_done_i) begin
            cu_done_d = 1'b1;
            ist_d[8]  = 1'b1;
        end
    end

`ifdef CGRA_CSR_PERF_EN
    logic [31:0] perf_q [NUM_CH];
    logic [31:0] perf_d [NUM_CH];

    always_comb begin
        perf_d = perf_q;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_acc[n] || (ch_sel[n] && off == 5'h18))
                perf_d[n] = '0;
            else if (dma_busy_i[n])
                perf_d[n] = perf_q[n] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) perf_q[n] <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end
`endif

    always_comb begin
        rd = 32'hDEAD_BEEF;
        if (g_hit) begin
            case (a)
                9'h000:  rd = ID_VAL;
                9'h004:  rd = 32'(ist_q);
                9'h008:  rd = mask_q;
                9'h010:  rd = {30'd0, cu_srst_q, 1'b0};
                9'h014:  rd = {29'd0, cu_pend_q, cu_done_q, cu_busy_i};
                9'h018:  rd = cu_cycles_i;
                default: rd = '0;
            endcase
        end else if (ch_ok) begin
            rd = '0;
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch == 3'(n)) begin
                    case (off)
                        5'h04: rd = {28'd0, err_q[n], pend_q[n],
                                     done_q[n], dma_busy_i[n]};
                        5'h08: rd = src_q[n];
                        5'h0C: rd = dst_q[n];
                        5'h10: rd = size_q[n];
                        5'h14: rd = 32'(cnt_q[n]);
`ifdef CGRA_CSR_PERF_EN
                        5'h18: rd = perf_q[n];
`endif
                        default: rd = '0;
                    endcase
                end
            end
        end
    end

    assign prdata  = DATA_WIDTH'(rd);
    assign pready  = 1'b1;
    assign pslverr = acc & (!(g_hit || ch_ok) || wr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                src_q[n]  <= '0;
                dst_q[n]  <= '0;
                size_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
            pend_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            ist_q     <= '0;
            mask_q    <= '0;
            cu_pend_q <= 1'b0;
            cu_done_q <= 1'b0;
            cu_srst_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ist_q     <= ist_d;
            mask_q    <= mask_d;
            cu_pend_q <= cu_pend_d;
            cu_done_q <= cu_done_d;
            cu_srst_q <= cu_srst_d;
            irq_q     <= |(ist_q & mask_q[8:0]);
        end
    end

    always_comb begin
        dma_src  = '0;
        dma_dst  = '0;
        dma_size = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            dma_src[32*n +: 32]  = src_q[n];
            dma_dst[32*n +: 32]  = dst_q[n];
            dma_size[32*n +: 32] = size_q[n];
        end
    end

    assign dma_start_valid = pend_q;
    assign cu_start_valid  = cu_pend_q;
    assign cu_soft_reset   = cu_srst_q;
    assign irq             = irq_q;

endmodule
